linear_dequant_scheduler: RTL

- Sequences one full matrix-vector job on a tiled, dequantizing linear datapath: OUT_TILES output tiles, each accumulated over IN_DEPTH input beats.
- Emits one address beat per datapath input beat: activation buffer address, weight buffer address, last-of-tile flag.
- Credit-limits in-flight beats so the datapath's per-beat max-num scale FIFO cannot overflow.
- Sits between the job controller (start/done) and the activation/weight buffer read ports that feed the linear datapath.

---
 rtl/linear_sched_pkg.sv | 15 +
 rtl/linear_sched_credit_counter.sv | 33 +++
 rtl/linear_dequant_scheduler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/linear_sched_pkg.sv
// Shared types and width helpers for the linear dequant scheduler.
package linear_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/linear_sched_credit_counter.sv
// In-flight beat credit tracking; a retire without a full tile of credit is
// flagged as underflow and not counted.
module linear_sched_credit_counter
  import linear_sched_pkg::*;
#(
  parameter int IN_DEPTH        = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int FW              = cnt_w(MAX_OUTSTANDING)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [FW-1:0] inflight,
  output logic          credit_ok,
  output logic          underflow
);

  logic retire;

  assign credit_ok = inflight < FW'(MAX_OUTSTANDING);
  assign underflow = dec & (inflight < FW'(IN_DEPTH));
  assign retire    = dec & ~underflow;

  // retire only when inflight >= IN_DEPTH, so the result never goes below 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     inflight <= '0;
    else if (clr) inflight <= '0;
    else          inflight <= inflight + FW'(inc) - (retire ? FW'(IN_DEPTH) : FW'(0));
  end

endmodule

// File: rtl/linear_dequant_scheduler.sv
// Address/credit sequencer for one tiled matrix-vector job.
// Optional LINEAR_SCHED_PERF_EN adds stall_cycles / credit_cycles counters.
module linear_dequant_scheduler
  import linear_sched_pkg::*;
#(
  parameter int IN_DEPTH        = 4,
  parameter int OUT_TILES       = 8,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ACT_ADDR_WIDTH  = 10,
  parameter int WGT_ADDR_WIDTH  = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_valid,
  output logic                      start_ready,
  input  logic [ACT_ADDR_WIDTH-1:0] act_base,
  input  logic [WGT_ADDR_WIDTH-1:0] wgt_base,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [ACT_ADDR_WIDTH-1:0] issue_act_addr,
  output logic [WGT_ADDR_WIDTH-1:0] issue_wgt_addr,
  output logic                      issue_last,
  input  logic                      out_fire,
  output logic                      busy,
  output logic                      done,
  output logic                      err
`ifdef LINEAR_SCHED_PERF_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               credit_cycles
`endif
);

  localparam int IW = cnt_w(IN_DEPTH - 1);
  localparam int OW = cnt_w(OUT_TILES - 1);
  localparam int RW = cnt_w(OUT_TILES);
  localparam int FW = cnt_w(MAX_OUTSTANDING);

  if (MAX_OUTSTANDING < IN_DEPTH || IN_DEPTH < 1 || OUT_TILES < 1) begin : g_cfg_chk
    $error("linear_dequant_scheduler: need IN_DEPTH>=1, OUT_TILES>=1, MAX_OUTSTANDING>=IN_DEPTH");
  end

  sched_state_e state, state_nxt;

  logic [IW-1:0]             in_cnt;
  logic [OW-1:0]             out_cnt;
  logic [RW-1:0]             retired, retired_eff;
  logic [FW-1:0]             inflight;
  logic [ACT_ADDR_WIDTH-1:0] act_base_q, act_addr_q;
  logic [WGT_ADDR_WIDTH-1:0] wgt_addr_q;
  logic                      credit_ok, underflow;
  logic                      start_fire, beat_fire, final_beat, retire_ok, job_done, err_set;
  logic                      done_q, err_q;

  assign start_ready    = (state == IDLE);
  assign start_fire     = start_valid & start_ready;
  assign issue_valid    = (state == ISSUE) & credit_ok;
  assign beat_fire      = issue_valid & issue_ready;
  assign issue_last     = (in_cnt == IW'(IN_DEPTH - 1));
  assign final_beat     = beat_fire & issue_last & (out_cnt == OW'(OUT_TILES - 1));
  assign retire_ok      = out_fire & (state != IDLE) & ~underflow;
  assign retired_eff    = retired + RW'(retire_ok);
  assign job_done       = (state == DRAIN) & (retired_eff == RW'(OUT_TILES));
  assign err_set        = (out_fire & (state == IDLE)) | underflow;
  assign issue_act_addr = act_addr_q;
  assign issue_wgt_addr = wgt_addr_q;
  assign busy           = (state != IDLE);
  assign done           = done_q;
  assign err            = err_q;

  linear_sched_credit_counter #(
    .IN_DEPTH        (IN_DEPTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .FW              (FW)
  ) u_credit (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_fire),
    .inc       (beat_fire),
    .dec       (out_fire & (state != IDLE)),
    .inflight  (inflight),
    .credit_ok (credit_ok),
    .underflow (underflow)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_fire) state_nxt = ISSUE;
      ISSUE:   if (final_beat) state_nxt = DRAIN;
      DRAIN:   if (job_done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // wgt address walks linearly across tiles; act address rewinds each tile
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt     <= '0;
      out_cnt    <= '0;
      retired    <= '0;
      act_base_q <= '0;
      act_addr_q <= '0;
      wgt_addr_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (start_fire) begin
        in_cnt     <= '0;
        out_cnt    <= '0;
        retired    <= '0;
        act_base_q <= act_base;
        act_addr_q <= act_base;
        wgt_addr_q <= wgt_base;
      end else if (beat_fire && !final_beat) begin
        wgt_addr_q <= wgt_addr_q + WGT_ADDR_WIDTH'(1);
        if (issue_last) begin
          in_cnt     <= '0;
          out_cnt    <= out_cnt + OW'(1);
          act_addr_q <= act_base_q;
        end else begin
          in_cnt     <= in_cnt + IW'(1);
          act_addr_q <= act_addr_q + ACT_ADDR_WIDTH'(1);
        end
      end
      if (retire_ok) retired <= retired_eff;
      done_q <= job_done;
      if (err_set)         err_q <= 1'b1;
      else if (start_fire) err_q <= 1'b0;
    end
  end

`ifdef LINEAR_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles  <= '0;
      credit_cycles <= '0;
    end else if (start_fire) begin
      stall_cycles  <= '0;
      credit_cycles <= '0;
    end else begin
      if (issue_valid && !issue_ready && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (state == ISSUE && !credit_ok && credit_cycles != '1)
        credit_cycles <= credit_cycles + 32'd1;
    end
  end
`endif

endmodule
